soft_ramp_ctrl: RTL
===================

Name: soft_ramp_ctrl

Overview:
- Parametrised successor to the fixed soft-start block in the SMPS control path.
- Generates a duty-select value that ramps at a programmable cadence toward a runtime target, then holds it.
- Tracks target changes up or down, supports a graceful soft-stop ramp to zero, and supports hard disable.
- Output feeds the PWM duty-select mux.

Parameters:
- DUTY_W, 8, width of duty select and target.
- TS_PERIOD, 10, clocks per switching period (≥2).
- TS_W, 10, width of the period counter; must hold TS_PERIOD-1.
- CYCLES_PER_STEP, 5, switching periods per duty step (≥1).
- CYC_W, 7, width of the cycle counter.
- STEP, 1, duty increment/decrement per step (≥1).

Ports:
- i_clk, in, 1, system clock.
- reset, in, 1, synchronous active-low reset; 0 = reset.
- i_enable, in, 1, converter enable; low = hard off.
- i_target, in, DUTY_W, desired steady-state duty; sampled every clock.
- i_stop, in, 1, soft-stop request (level).
- o_duty_sel, out, DUTY_W, current duty select (registered).
- o_enable, out, 1, power stage enable = i_enable && o_duty_sel!=0 && state!=IDLE (combinational).
- o_done, out, 1, high only in HOLD (registered).
- o_busy, out, 1, high in RAMP or STOP (registered).

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, o_duty_sel=0, o_done=0, o_busy=0, period counter=TS_PERIOD-1, cycle counter=CYCLES_PER_STEP-1. Applies mid-ramp with no ramp-down.
- Tick generator: counters are held at their load values in IDLE and run in all other states.
  - Period counter decrements each clock. ts_tick is asserted when it equals 0, and the counter reloads to TS_PERIOD-1.
  - Cycle counter decrements on ts_tick. step_tick = ts_tick && cycle==0, and the cycle counter then reloads.
  - Result: one step_tick every TS_PERIOD*CYCLES_PER_STEP clocks (50 at defaults). The first one comes exactly that many clocks after leaving IDLE.
  - Counters do not restart on target changes or on entering or leaving STOP.
- States: IDLE, RAMP, HOLD, STOP.
- Priority each clock: reset > !i_enable > i_stop > target tracking.
- IDLE:
  - i_enable=1 and i_stop=0 -> RAMP.
  - If i_target==0, go directly to HOLD instead.
- Any non-IDLE state with i_enable=0 -> IDLE next edge; o_duty_sel=0 at that same edge (hard off).
- RAMP:
  - On step_tick, o_duty_sel moves toward i_target by STEP, saturating at i_target. Arithmetic is DUTY_W+1 bits, with no wrap at 0 or at 2^DUTY_W-1.
  - When the new value equals i_target, enter HOLD at the same edge, so o_done rises together with the final duty value.
- HOLD:
  - If i_target != o_duty_sel -> RAMP next edge (o_done drops). The duty is unchanged until the next step_tick.
- i_stop=1 in RAMP or HOLD -> STOP.
- STOP:
  - On step_tick, duty decreases by STEP, saturating at 0.
  - When the new value is 0 -> IDLE at the same edge.
  - If i_stop falls while i_enable=1 -> RAMP (resume toward target).
- Restart after STOP->IDLE requires i_stop=0; i_enable may stay high.
- o_done=0 and o_busy=0 in IDLE.
- Target changes mid-ramp take effect at the next step_tick. An overshoot is corrected by reversing direction; there is no jump.

Decomposition:
- smps_pkg holds:
  - state enum ramp_state_t {IDLE, RAMP, HOLD, STOP};
  - default constants DEF_TS_PERIOD=10, DEF_CYCLES_PER_STEP=5, DEF_STEP=1.
- One sub-module, ramp_tick_gen: period and cycle counters. It takes a run input and produces the step_tick output, reusing the existing down_counter.
- The FSM and duty register stay in soft_ramp_ctrl.

Test Plan:
- Defaults, target=4, assert i_enable at edge E0 -> o_duty_sel=1,2,3,4 at E0+50,+100,+150,+200; o_done=1 at E0+200; o_enable rises at E0+50.
- HOLD at 4, set target=2 -> o_done drops the next edge; duty 3 then 2 at the next two step_ticks 50 clocks apart; o_done re-asserts with duty=2.
- HOLD at 4, assert i_stop -> duty 3,2,1,0 on successive step_ticks (first within 50 clocks); state IDLE and o_busy=0 at the edge duty hits 0; o_enable=0 from then on.
- Mid-ramp at duty 2, drop i_enable -> o_duty_sel=0 and IDLE at the next edge. Re-enable -> first step exactly 50 clocks later.
- STEP=3, DUTY_W=8, target=250 -> duty saturates 249->250 with no wrap. Then target=0 -> ramps down to 0 and HOLD with o_done=1, o_enable=0.
- Pulse reset low mid-STOP -> all outputs 0 on the next edge. Enable with target=0 -> HOLD immediately, o_duty_sel=0.

Source files
------------

// File: rtl/smps_pkg.sv
// Shared types and default timing constants for the SMPS soft-start/soft-stop control path.
package smps_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } ramp_state_t;

  localparam int DEF_TS_PERIOD       = 10;
  localparam int DEF_CYCLES_PER_STEP = 5;
  localparam int DEF_STEP            = 1;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that wraps back to its load value after reaching zero.
module down_counter #(
  parameter int           W    = 8,
  parameter logic [W-1:0] LOAD = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset || load) begin
      count <= LOAD;
    end else if (en) begin
      count <= (count == '0) ? LOAD : count - 1'b1;
    end
  end

endmodule

// File: rtl/ramp_tick_gen.sv
// Switching-period and step cadence generator; both counters sit at their load values while run is low.
module ramp_tick_gen import smps_pkg::*; #(
  parameter int TS_PERIOD       = DEF_TS_PERIOD,
  parameter int TS_W            = 10,
  parameter int CYCLES_PER_STEP = DEF_CYCLES_PER_STEP,
  parameter int CYC_W           = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic step_tick
);

  logic [TS_W-1:0]  period;
  logic [CYC_W-1:0] cycle;
  logic             ts_tick;

  down_counter #(
    .W    (TS_W),
    .LOAD (TS_W'(TS_PERIOD - 1))
  ) u_period (
    .clk   (clk),
    .reset (reset),
    .load  (!run),
    .en    (run),
    .count (period)
  );

  assign ts_tick = run && (period == '0);

  down_counter #(
    .W    (CYC_W),
    .LOAD (CYC_W'(CYCLES_PER_STEP - 1))
  ) u_cycle (
    .clk   (clk),
    .reset (reset),
    .load  (!run),
    .en    (ts_tick),
    .count (cycle)
  );

  assign step_tick = ts_tick && (cycle == '0);

endmodule

// File: rtl/soft_ramp_ctrl.sv
// Soft-start / soft-stop duty ramp controller feeding the PWM duty-select mux.
module soft_ramp_ctrl import smps_pkg::*; #(
  parameter int DUTY_W          = 8,
  parameter int TS_PERIOD       = DEF_TS_PERIOD,
  parameter int TS_W            = 10,
  parameter int CYCLES_PER_STEP = DEF_CYCLES_PER_STEP,
  parameter int CYC_W           = 7,
  parameter int STEP            = DEF_STEP
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic [DUTY_W-1:0] i_target,
  input  logic              i_stop,
  output logic [DUTY_W-1:0] o_duty_sel,
  output logic              o_enable,
  output logic              o_done,
  output logic              o_busy,
  output logic [1:0]        dbg_state
);

  localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(STEP);

  ramp_state_t     state;
  logic            step_tick;
  logic [DUTY_W:0] duty_x;
  logic [DUTY_W:0] target_x;
  logic [DUTY_W:0] toward_x;
  logic [DUTY_W:0] down_x;

  ramp_tick_gen #(
    .TS_PERIOD       (TS_PERIOD),
    .TS_W            (TS_W),
    .CYCLES_PER_STEP (CYCLES_PER_STEP),
    .CYC_W           (CYC_W)
  ) u_tick (
    .clk       (i_clk),
    .reset     (reset),
    .run       (state != IDLE),
    .step_tick (step_tick)
  );

  assign duty_x   = {1'b0, o_duty_sel};
  assign target_x = {1'b0, i_target};

  // One extra bit of headroom so a step never wraps past 0 or full scale.
  always_comb begin
    toward_x = target_x;
    down_x   = '0;
    if (duty_x < target_x) begin
      toward_x = (duty_x + STEP_X > target_x) ? target_x : duty_x + STEP_X;
    end else begin
      toward_x = (duty_x > target_x + STEP_X) ? duty_x - STEP_X : target_x;
    end
    if (duty_x > STEP_X) begin
      down_x = duty_x - STEP_X;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset || !i_enable) begin
      state      <= IDLE;
      o_duty_sel <= '0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_stop) begin
            if (i_target == '0) begin
              state  <= HOLD;
              o_done <= 1'b1;
            end else begin
              state  <= RAMP;
              o_busy <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (i_stop) begin
            state <= STOP;
          end else if (step_tick) begin
            o_duty_sel <= toward_x[DUTY_W-1:0];
            if (toward_x == target_x) begin
              state  <= HOLD;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (i_stop) begin
            state  <= STOP;
            o_done <= 1'b0;
            o_busy <= 1'b1;
          end else if (i_target != o_duty_sel) begin
            state  <= RAMP;
            o_done <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        STOP: begin
          if (!i_stop) begin
            state <= RAMP;
          end else if (step_tick) begin
            o_duty_sel <= down_x[DUTY_W-1:0];
            if (down_x == '0) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_enable  = i_enable && (o_duty_sel != '0) && (state != IDLE);
  assign dbg_state = state;

endmodule
